// File: rtl/qed_mem_checker.sv
// QED memory consistency checker: scans original/duplicate halves of data memory
// through a one-cycle-latency read port and reports the first mismatching pair.
module qed_mem_checker #(
  parameter int DEPTH  = 32,
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic [DATA_W-1:0] mem_data_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              result_vld_o,
  output logic              match_o,
  output logic [ADDR_W-2:0] mismatch_idx_o
);

  localparam int H = DEPTH / 2;
  localparam logic [ADDR_W-1:0] HALF     = ADDR_W'(H);
  localparam logic [ADDR_W-2:0] LAST_IDX = (ADDR_W-1)'(H - 1);
  localparam logic [ADDR_W-2:0] IDX_ONE  = (ADDR_W-1)'(1);
  localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
  localparam logic [ADDR_W-2:0] IDX_ZERO  = {(ADDR_W-1){1'b0}};

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ORIG = 2'd1;
  localparam logic [1:0] ST_DUP  = 2'd2;
  localparam logic [1:0] ST_LAST = 2'd3;

  logic [1:0]        state_r;
  logic [ADDR_W-2:0] idx_r;
  logic [ADDR_W-2:0] cmp_idx_r;
  logic [DATA_W-1:0] orig_q_r;
  logic              pend_r;
  logic [ADDR_W-1:0] addr_r;
  logic              busy_r;
  logic              done_r;
  logic              vld_r;
  logic              match_r;
  logic [ADDR_W-2:0] mm_idx_r;
  logic              cmp_en_s;
  logic              cmp_ne_s;

  // Decide whether the word on the read port closes a pending pair compare
  always_comb begin
    cmp_en_s = 1'b0;
    cmp_ne_s = (orig_q_r != mem_data_i);
    case (state_r)
      ST_ORIG: cmp_en_s = pend_r;
      ST_LAST: cmp_en_s = 1'b1;
      default: cmp_en_s = 1'b0;
    endcase
  end

  // Scan FSM, address generation and verdict registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r   <= ST_IDLE;
      idx_r     <= IDX_ZERO;
      cmp_idx_r <= IDX_ZERO;
      orig_q_r  <= {DATA_W{1'b0}};
      pend_r    <= 1'b0;
      addr_r    <= ADDR_ZERO;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      vld_r     <= 1'b0;
      match_r   <= 1'b0;
      mm_idx_r  <= IDX_ZERO;
    end else begin
      done_r <= 1'b0;
      // first mismatch wins: the index only latches while match is still set
      if (cmp_en_s && cmp_ne_s) begin
        match_r <= 1'b0;
        if (match_r) begin
          mm_idx_r <= cmp_idx_r;
        end
      end
      case (state_r)
        ST_IDLE: begin
          addr_r <= ADDR_ZERO;
          if (start_i) begin
            state_r  <= ST_ORIG;
            idx_r    <= IDX_ZERO;
            match_r  <= 1'b1;
            mm_idx_r <= IDX_ZERO;
            vld_r    <= 1'b0;
            pend_r   <= 1'b0;
            busy_r   <= 1'b1;
          end else begin
            busy_r <= 1'b0;
          end
        end
        ST_ORIG: begin
          addr_r  <= {1'b0, idx_r} + HALF;
          state_r <= ST_DUP;
        end
        ST_DUP: begin
          orig_q_r  <= mem_data_i;
          pend_r    <= 1'b1;
          cmp_idx_r <= idx_r;
          if (idx_r == LAST_IDX) begin
            addr_r  <= ADDR_ZERO;
            state_r <= ST_LAST;
          end else begin
            idx_r   <= idx_r + IDX_ONE;
            addr_r  <= {1'b0, idx_r + IDX_ONE};
            state_r <= ST_ORIG;
          end
        end
        ST_LAST: begin
          addr_r  <= ADDR_ZERO;
          state_r <= ST_IDLE;
          done_r  <= 1'b1;
          vld_r   <= 1'b1;
          busy_r  <= 1'b0;
          pend_r  <= 1'b0;
        end
        default: begin
          addr_r  <= ADDR_ZERO;
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign mem_addr_o     = addr_r;
  assign busy_o         = busy_r;
  assign done_o         = done_r;
  assign result_vld_o   = vld_r;
  assign match_o        = match_r;
  assign mismatch_idx_o = mm_idx_r;

endmodule

// File: tb/tb_qed_mem_checker.sv
// Directed bench for qed_mem_checker with a one-cycle-latency RAM model on read port B.
module tb_qed_mem_checker;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        start_i = 1'b0;
  logic [4:0]  mem_addr_o;
  logic [31:0] mem_data_i = 32'h0;
  logic        busy_o;
  logic        done_o;
  logic        result_vld_o;
  logic        match_o;
  logic [3:0]  mismatch_idx_o;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] mem [0:31];
  logic [4:0]  addr_log  [0:99];
  logic        busy_log  [0:99];
  logic        done_log  [0:99];
  logic        vld_log   [0:99];
  logic        match_log [0:99];
  logic [3:0]  mm_log    [0:99];
  int          done_cyc;
  int          done_cnt;

  qed_mem_checker #(.DEPTH(32), .ADDR_W(5), .DATA_W(32)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i),
    .mem_addr_o(mem_addr_o), .mem_data_i(mem_data_i),
    .busy_o(busy_o), .done_o(done_o), .result_vld_o(result_vld_o),
    .match_o(match_o), .mismatch_idx_o(mismatch_idx_o)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) mem_data_i <= mem[mem_addr_o];

  task automatic load_matched();
    for (int i = 0; i < 16; i++) begin
      mem[i]      = 32'hA5A5_0000 + i;
      mem[i + 16] = 32'hA5A5_0000 + i;
    end
  endtask

  // Start a scan at edge 0, then log outputs mid-cycle for cycles 1..n.
  task automatic run_scan(input int n, input int restart_cyc, input int rst_cyc);
    done_cyc = -1;
    done_cnt = 0;
    @(negedge clk_i);
    start_i = 1'b1;
    @(posedge clk_i);
    #1 start_i = 1'b0;
    for (int c = 1; c <= n; c++) begin
      @(negedge clk_i);
      addr_log[c]  = mem_addr_o;
      busy_log[c]  = busy_o;
      done_log[c]  = done_o;
      vld_log[c]   = result_vld_o;
      match_log[c] = match_o;
      mm_log[c]    = mismatch_idx_o;
      if (done_o === 1'b1) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = c;
      end
      start_i = (c == restart_cyc) ? 1'b1 : 1'b0;
      rst_i   = (c == rst_cyc) ? 1'b1 : 1'b0;
    end
    @(negedge clk_i);
    start_i = 1'b0;
    rst_i   = 1'b0;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    start_i = 1'b1;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    n_cmp++; if (mem_addr_o !== 5'd0) begin n_err++; $display("FAIL reset_addr got %0d want 0", mem_addr_o); end
    n_cmp++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", busy_o); end
    n_cmp++; if (done_o !== 1'b0) begin n_err++; $display("FAIL reset_done got %b want 0", done_o); end
    n_cmp++; if (result_vld_o !== 1'b0) begin n_err++; $display("FAIL reset_vld got %b want 0", result_vld_o); end
    n_cmp++; if (match_o !== 1'b0) begin n_err++; $display("FAIL reset_match got %b want 0", match_o); end
    n_cmp++; if (mismatch_idx_o !== 4'd0) begin n_err++; $display("FAIL reset_mm_idx got %0d want 0", mismatch_idx_o); end
    rst_i = 1'b0;
    start_i = 1'b0;
  endtask

  task automatic test_matched();
    load_matched();
    run_scan(40, -1, -1);
    n_cmp++; if (done_cyc !== 34) begin n_err++; $display("FAIL matched_done_cyc got %0d want 34", done_cyc); end
    n_cmp++; if (done_cnt !== 1) begin n_err++; $display("FAIL matched_done_cnt got %0d want 1", done_cnt); end
    n_cmp++; if (vld_log[33] !== 1'b0 || vld_log[34] !== 1'b1) begin n_err++; $display("FAIL matched_vld got %b%b want 01", vld_log[33], vld_log[34]); end
    n_cmp++; if (match_log[34] !== 1'b1) begin n_err++; $display("FAIL matched_match got %b want 1", match_log[34]); end
    n_cmp++; if (mm_log[34] !== 4'd0) begin n_err++; $display("FAIL matched_mm_idx got %0d want 0", mm_log[34]); end
    for (int c = 1; c <= 40; c++) begin
      logic exp_b;
      exp_b = (c <= 33) ? 1'b1 : 1'b0;
      n_cmp++; if (busy_log[c] !== exp_b) begin n_err++; $display("FAIL matched_busy cyc %0d got %b want %b", c, busy_log[c], exp_b); end
    end
  endtask

  task automatic test_addr_seq();
    for (int c = 1; c <= 34; c++) begin
      int exp_a;
      if (c > 32) exp_a = 0;
      else if (c % 2 == 1) exp_a = (c - 1) / 2;
      else exp_a = 16 + (c - 2) / 2;
      n_cmp++; if (addr_log[c] !== exp_a[4:0]) begin n_err++; $display("FAIL addr_seq cyc %0d got %0d want %0d", c, addr_log[c], exp_a); end
    end
  endtask

  task automatic test_single_mismatch();
    load_matched();
    mem[21] = 32'hDEAD_BEEF;
    run_scan(40, -1, -1);
    n_cmp++; if (done_cyc !== 34) begin n_err++; $display("FAIL single_done_cyc got %0d want 34", done_cyc); end
    n_cmp++; if (match_log[34] !== 1'b0) begin n_err++; $display("FAIL single_match got %b want 0", match_log[34]); end
    n_cmp++; if (mm_log[34] !== 4'd5) begin n_err++; $display("FAIL single_mm_idx got %0d want 5", mm_log[34]); end
  endtask

  task automatic test_multi_mismatch();
    load_matched();
    mem[19] = 32'h1111_2222;
    mem[30] = 32'h3333_4444;
    run_scan(40, -1, -1);
    n_cmp++; if (match_log[34] !== 1'b0) begin n_err++; $display("FAIL multi_match got %b want 0", match_log[34]); end
    n_cmp++; if (mm_log[34] !== 4'd3) begin n_err++; $display("FAIL multi_mm_idx got %0d want 3", mm_log[34]); end
    load_matched();
    mem[0] = 32'h0BAD_0000;
    run_scan(40, -1, -1);
    n_cmp++; if (vld_log[34] !== 1'b1 || match_log[34] !== 1'b0) begin n_err++; $display("FAIL word0_match got vld %b match %b want vld 1 match 0", vld_log[34], match_log[34]); end
    n_cmp++; if (mm_log[34] !== 4'd0) begin n_err++; $display("FAIL word0_mm_idx got %0d want 0", mm_log[34]); end
  endtask

  task automatic test_start_handling();
    load_matched();
    run_scan(40, 10, -1);
    n_cmp++; if (done_cyc !== 34) begin n_err++; $display("FAIL busy_start_done_cyc got %0d want 34", done_cyc); end
    n_cmp++; if (done_cnt !== 1) begin n_err++; $display("FAIL busy_start_done_cnt got %0d want 1", done_cnt); end
    n_cmp++; if (match_log[34] !== 1'b1) begin n_err++; $display("FAIL busy_start_match got %b want 1", match_log[34]); end
    run_scan(80, 34, -1);
    n_cmp++; if (vld_log[34] !== 1'b1 || vld_log[35] !== 1'b0) begin n_err++; $display("FAIL b2b_vld got %b%b want 10", vld_log[34], vld_log[35]); end
    n_cmp++; if (busy_log[35] !== 1'b1) begin n_err++; $display("FAIL b2b_busy got %b want 1", busy_log[35]); end
    n_cmp++; if (done_cnt !== 2 || done_log[68] !== 1'b1) begin n_err++; $display("FAIL b2b_second_done got cnt %0d d68 %b want cnt 2 d68 1", done_cnt, done_log[68]); end
  endtask

  task automatic test_reset_mid_scan();
    load_matched();
    run_scan(40, -1, 12);
    n_cmp++; if (busy_log[12] !== 1'b1) begin n_err++; $display("FAIL rst_mid_busy_before got %b want 1", busy_log[12]); end
    n_cmp++; if (busy_log[13] !== 1'b0 || addr_log[13] !== 5'd0 || done_log[13] !== 1'b0) begin n_err++; $display("FAIL rst_mid_ctl got busy %b addr %0d done %b want 0 0 0", busy_log[13], addr_log[13], done_log[13]); end
    n_cmp++; if (vld_log[13] !== 1'b0 || match_log[13] !== 1'b0 || mm_log[13] !== 4'd0) begin n_err++; $display("FAIL rst_mid_verdict got vld %b match %b idx %0d want 0 0 0", vld_log[13], match_log[13], mm_log[13]); end
    n_cmp++; if (done_cnt !== 0) begin n_err++; $display("FAIL rst_mid_no_done got %0d want 0", done_cnt); end
    run_scan(40, -1, -1);
    n_cmp++; if (done_cyc !== 34 || match_log[34] !== 1'b1 || vld_log[34] !== 1'b1) begin n_err++; $display("FAIL rst_mid_rescan got cyc %0d match %b vld %b want 34 1 1", done_cyc, match_log[34], vld_log[34]); end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 32'h0;
    test_reset();
    test_matched();
    test_addr_seq();
    test_single_mismatch();
    test_multi_mismatch();
    test_start_handling();
    test_reset_mid_scan();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/qed_mem_checker.md
# qed_mem_checker

Read-side counterpart to `qed_mem_shim`: once a QED original/duplicate instruction sequence has drained, this block scans data memory through `d_mem` read port B (ADDRB/DOUTB) and compares every word in the original half with its partner in the duplicate half. It reports a single QED consistency verdict and the index of the first mismatching pair. It sits in `design_top` beside `d_mem`, driving ADDRB and consuming DOUTB, which are otherwise unused. The formal property is `result_vld_o -> match_o`.

## Interface
- `DEPTH`, 32: data-memory depth in words; must be an even power of two, ≥2. H = DEPTH/2.
- `ADDR_W`, 5: word-address width; equals $clog2(DEPTH).
- `DATA_W`, 32: memory word width.

Ports:
- `clk_i`  in  1  single clock; all logic is rising-edge.
- `rst_i`  in  1  synchronous, active-high reset.
- `start_i`  in  1  scan request; sampled only in IDLE, ignored otherwise.
- `mem_addr_o`  out  ADDR_W  word address to RAM read port (ADDRB).
- `mem_data_i`  in  DATA_W  RAM read data (DOUTB); valid one cycle after the address.
- `busy_o`  out  1  scan in progress.
- `done_o`  out  1  one-cycle pulse when a scan completes.
- `result_vld_o`  out  1  verdict valid; set with `done_o`, held until the next accepted start or reset.
- `match_o`  out  1  all H pairs equal; meaningful only while `result_vld_o` = 1.
- `mismatch_idx_o`  out  ADDR_W-1  index i of the first pair with word[i] != word[i+H]. Holds 0 if all pairs match.

## Operation
- The pair index `idx` counts 0..H-1. Original word is at address idx; duplicate word is at idx+H. The sum is formed in ADDR_W bits and never overflows.
- FSM states: IDLE, ORIG, DUP, LAST.
  - IDLE: `mem_addr_o` = 0. On `start_i`: idx←0, match_o←1, mismatch_idx_o←0, result_vld_o←0, then go to ORIG.
  - ORIG: `mem_addr_o` = idx. If a compare is pending, compare `orig_q` with `mem_data_i` (the previous duplicate word). Go to DUP.
  - DUP: `mem_addr_o` = idx+H. Capture `orig_q` ← `mem_data_i` (original word[idx]). Set the compare-pending flag. If idx = H-1, go to LAST; otherwise idx←idx+1 and go to ORIG.
  - LAST: `mem_addr_o` = 0. Perform the final compare. Then done_o←1, result_vld_o←1, and go to IDLE.
- On compare mismatch: match_o←0. mismatch_idx_o takes the compared pair's index only if match_o was still 1, so the first mismatch wins and later mismatches do not overwrite it.
- The scan always runs the full H pairs; there is no early abort. This keeps latency fixed.
- `busy_o` = 1 in ORIG, DUP and LAST.
- The block never writes memory. Memory contents changing mid-scan is outside the contract.

## Timing
- Reset values: FSM in IDLE, `mem_addr_o` = 0, `busy_o` = 0, `done_o` = 0, `result_vld_o` = 0, `match_o` = 0, `mismatch_idx_o` = 0, compare-pending flag = 0.
- Scan timeline, with `start_i` sampled at edge of cycle 0:
  - Cycles 1..2H: ORIG/DUP alternate. Pair k is addressed in cycles 2k+1 (original) and 2k+2 (duplicate).
  - Pair k is compared in cycle 2k+3. For the last pair this is cycle 2H+1, which is the LAST state.
  - `done_o` is high in cycle 2H+2 only; with DEPTH = 32 that is cycle 34. `result_vld_o` rises in the same cycle.
- `busy_o` is high in cycles 1..2H+1.
- The done cycle is in IDLE, so a `start_i` asserted during the `done_o` cycle is accepted. That start clears `result_vld_o` on the next cycle.
- `start_i` during busy: ignored, with no effect on the running scan.
- `rst_i` mid-scan: next cycle all outputs are at reset values. No `done_o` pulse. Partial results are discarded.
- `rst_i` and `start_i` together: reset wins.

## Test plan
- **Matched memory:** preload word[i] = word[i+16] = 32'hA5A5_0000+i for i = 0..15; pulse start → `done_o` in cycle 34, `match_o` = 1, `mismatch_idx_o` = 0, `busy_o` high exactly in cycles 1..33.
- **Single mismatch:** as above but word[21] = 32'hDEAD_BEEF → `match_o` = 0, `mismatch_idx_o` = 5.
- **Multiple mismatches:** corrupt word[19] and word[30] → `mismatch_idx_o` = 3, not 14. Also corrupt word[0] only → `mismatch_idx_o` = 0 with `match_o` = 0.
- **Address sequence:** check `mem_addr_o` = 0, 16, 1, 17, …, 15, 31 in cycles 1..32, then 0 in cycles 33 and 34.
- **Start handling:** start pulsed in cycle 10 of a scan → ignored, `done_o` still in cycle 34. Start asserted in the `done_o` cycle → new scan begins and `result_vld_o` drops the following cycle.
- **Reset mid-scan:** assert `rst_i` in cycle 12 → all outputs at reset values in cycle 13, no `done_o`. A fresh start afterwards completes normally.
